instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the decode/control logic. Holds the PC and fetches one instruction at a

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch stage with PC, redirect and timeout
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] alu_result,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;

    localparam logic [XLEN-1:0] PC_INC   = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MSK = ~XLEN'(1);
    localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            drop_q, drop_d;
    logic            err_q, err_d;
    // live_q keeps imem_req low during reset and for the first cycle after it
    logic            live_q, live_d;
    logic [XLEN-1:0] next_pc;

    assign imem_req    = live_q && (state_q == S_FETCH) && !drop_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[31:25];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_INC;
    assign fetch_err   = err_q;

    // Next-PC select applied at retire; code 11 behaves as sequential
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            2'b01:   next_pc = pc_target;
            2'b10:   next_pc = alu_result & JALR_MSK;
            default: next_pc = pc_plus4;
        endcase
    end

    // Fetch FSM next state; flush is applied last so it overrides every other update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        err_d   = err_q;
        live_d  = 1'b1;

        // the response owed to an abandoned request retires the drop flag
        if (drop_q && imem_rvalid) begin
            drop_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (imem_req && imem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = S_VALID;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    pc_d = next_pc;
                    if (next_pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (flush) begin
            state_d = S_FETCH;
            pc_d    = flush_pc;
            instr_d = instr_q;
            cnt_d   = '0;
            err_d   = (flush_pc[1:0] == 2'b00) ? 1'b0 : err_q;
            // a granted request whose data has not arrived must have its response swallowed
            if ((state_q == S_WAIT && !imem_rvalid) || (imem_req && imem_gnt)) begin
                drop_d = 1'b1;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_src;
    logic [31:0] pc_target;
    logic [31:0] alu_result;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_err;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;
    logic        exp_err;
    logic [31:0] last_word;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .op(op), .funct3(funct3), .funct7(funct7),
        .pc(pc), .pc_plus4(pc_plus4),
        .pc_src(pc_src), .pc_target(pc_target), .alu_result(alu_result),
        .flush(flush), .flush_pc(flush_pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (imem_req !== 1'b1) begin
            fails++;
            $display("FAIL %s req_wait imem_req=%b required 1", nm, imem_req);
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int gd, input int rd,
                            input logic [31:0] word, input string nm);
        logic [31:0] pc4;
        wait_req(nm);
        tests++;
        if (imem_addr !== addr) begin
            fails++;
            $display("FAIL %s addr imem_addr=%h required %h", nm, imem_addr, addr);
        end
        for (int i = 0; i < gd; i++) begin
            tick();
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== addr || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s stall req=%b addr=%h valid=%b required 1 %h 0",
                         nm, imem_req, imem_addr, instr_valid, addr);
            end
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s wait req=%b valid=%b required 0 0", nm, imem_req, instr_valid);
        end
        for (int i = 0; i < rd; i++) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        last_word   = word;
        pc4 = addr + 32'd4;
        tests++;
        if (instr_valid !== 1'b1 || instr !== word || pc !== addr || pc_plus4 !== pc4) begin
            fails++;
            $display("FAIL %s present valid=%b instr=%h pc=%h pc4=%h required 1 %h %h %h",
                     nm, instr_valid, instr, pc, pc_plus4, word, addr, pc4);
        end
        tests++;
        if (op !== word[6:0] || funct3 !== word[14:12] || funct7 !== word[31:25]) begin
            fails++;
            $display("FAIL %s fields op=%h f3=%h f7=%h required %h %h %h",
                     nm, op, funct3, funct7, word[6:0], word[14:12], word[31:25]);
        end
    endtask

    task automatic retire(input logic [1:0] src, input logic [31:0] tgt,
                          input logic [31:0] alu, input string nm);
        logic [31:0] nxt;
        case (src)
            2'b01:   nxt = tgt;
            2'b10:   nxt = {alu[31:1], 1'b0};
            default: nxt = exp_pc + 32'd4;
        endcase
        instr_ready = 1'b1;
        pc_src      = src;
        pc_target   = tgt;
        alu_result  = alu;
        tick();
        instr_ready = 1'b0;
        pc_src      = 2'($urandom);
        exp_pc      = nxt;
        if (nxt[1:0] != 2'b00) exp_err = 1'b1;
        tests++;
        if (instr_valid !== 1'b0 || pc !== exp_pc || fetch_err !== exp_err) begin
            fails++;
            $display("FAIL %s retire valid=%b pc=%h err=%b required 0 %h %b",
                     nm, instr_valid, pc, fetch_err, exp_pc, exp_err);
        end
        tests++;
        if (imem_req !== !exp_err) begin
            fails++;
            $display("FAIL %s after_retire imem_req=%b required %b", nm, imem_req, !exp_err);
        end
    endtask

    task automatic do_flush(input logic [31:0] addr, input string nm);
        flush    = 1'b1;
        flush_pc = addr;
        tick();
        flush    = 1'b0;
        exp_pc   = addr;
        if (addr[1:0] == 2'b00) exp_err = 1'b0;
        tests++;
        if (pc !== exp_pc || fetch_err !== exp_err || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s flush pc=%h err=%b valid=%b required %h %b 0",
                     nm, pc, fetch_err, instr_valid, exp_pc, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
        pc_src = 0; pc_target = 0; alu_result = 0; flush = 0; flush_pc = 0;
        exp_pc = 32'h0; exp_err = 1'b0; last_word = 32'h13;
        tick();
        tick();
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || pc !== 32'h0 ||
            instr !== 32'h13 || op !== 7'h13 || funct3 !== 3'h0 || funct7 !== 7'h0) begin
            fails++;
            $display("FAIL reset req=%b valid=%b err=%b pc=%h instr=%h required 0 0 0 0 00000013",
                     imem_req, instr_valid, fetch_err, pc, instr);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_first_req req=%b addr=%h required 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        do_fetch(32'h0, 0, 0, 32'h0050_0093, "basic");
        tests++;
        if (op !== 7'h13 || funct3 !== 3'h0 || pc_plus4 !== 32'h4) begin
            fails++;
            $display("FAIL basic_const op=%h f3=%h pc4=%h required 13 0 4", op, funct3, pc_plus4);
        end
    endtask

    task automatic test_redirect();
        retire(2'b01, 32'h40, 32'h0, "jal");
        do_fetch(32'h40, 0, 1, $urandom, "jal_fetch");
        retire(2'b10, 32'h0, 32'h81, "jalr");
        do_fetch(32'h80, 5, 2, $urandom, "gnt_stall");
        retire(2'b11, 32'h0, 32'h0, "src11");
    endtask

    task automatic test_timeout();
        wait_req("timeout");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        tests++;
        if (fetch_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early fetch_err=%b required 0", fetch_err);
        end
        tick();
        tests++;
        if (fetch_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_err fetch_err=%b required 1", fetch_err);
        end
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1) begin
            fails++;
            $display("FAIL halt req=%b valid=%b err=%b required 0 0 1", imem_req, instr_valid, fetch_err);
        end
        exp_err = 1'b1;
        do_flush(32'h100, "halt_flush");
        do_fetch(32'h100, 1, 3, $urandom, "after_halt");
        retire(2'b00, 32'h0, 32'h0, "after_halt");
    endtask

    task automatic test_flush_wait();
        wait_req("flush_wait");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        tick();
        do_flush(32'h300, "flush_wait");
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL drop_req0 imem_req=%b required 0", imem_req);
        end
        tick();
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL drop_req1 imem_req=%b required 0", imem_req);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || instr !== last_word || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            fails++;
            $display("FAIL stale valid=%b instr=%h req=%b addr=%h required 0 %h 1 00000300",
                     instr_valid, instr, imem_req, imem_addr, last_word);
        end
        do_fetch(32'h300, 0, 0, $urandom, "post_drop");
        // flush together with instr_ready: flush wins
        instr_ready = 1'b1;
        pc_src      = 2'b01;
        pc_target   = 32'h44;
        do_flush(32'h500, "flush_ready");
        instr_ready = 1'b0;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin
            fails++;
            $display("FAIL flush_ready_req req=%b addr=%h required 1 00000500", imem_req, imem_addr);
        end
        // flush together with rvalid: data discarded, no drop owed
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        do_flush(32'h600, "flush_rvalid");
        imem_rvalid = 1'b0;
        tests++;
        if (instr !== last_word || imem_req !== 1'b1 || imem_addr !== 32'h600) begin
            fails++;
            $display("FAIL flush_rvalid instr=%h req=%b addr=%h required %h 1 00000600",
                     instr, imem_req, imem_addr, last_word);
        end
        // spurious rvalid in FETCH is ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || instr !== last_word || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL spurious valid=%b instr=%h req=%b required 0 %h 1", instr_valid, instr, imem_req, last_word);
        end
        do_fetch(32'h600, 2, 0, $urandom, "after_spurious");
        retire(2'b00, 32'h0, 32'h0, "after_spurious");
    endtask

    task automatic test_wrap_misalign();
        do_flush(32'hFFFF_FFFC, "wrap");
        do_fetch(32'hFFFF_FFFC, 0, 0, $urandom, "wrap_fetch");
        retire(2'b00, 32'h0, 32'h0, "wrap");
        do_fetch(32'h0, 0, 0, $urandom, "wrap_zero");
        retire(2'b01, 32'h42, 32'h0, "misalign");
        tick();
        tick();
        tests++;
        if (imem_req !== 1'b0 || fetch_err !== 1'b1 || pc !== 32'h42) begin
            fails++;
            $display("FAIL misalign_halt req=%b err=%b pc=%h required 0 1 00000042", imem_req, fetch_err, pc);
        end
        do_flush(32'h3, "flush_misaligned");
        do_flush(32'h200, "flush_aligned");
        do_fetch(32'h200, 0, 1, $urandom, "after_err");
        retire(2'b00, 32'h0, 32'h0, "after_err");
    endtask

    task automatic test_reset_mid_wait();
        wait_req("rst_wait");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        exp_pc  = 32'h0;
        exp_err = 1'b0;
        last_word = 32'h13;
        tests++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h13) begin
            fails++;
            $display("FAIL async_reset req=%b pc=%h valid=%b instr=%h required 0 0 0 00000013",
                     imem_req, pc, instr_valid, instr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL rst_discard valid=%b req=%b addr=%h required 0 1 0", instr_valid, imem_req, imem_addr);
        end
        do_fetch(32'h0, 0, 0, $urandom, "after_rst");
        retire(2'b00, 32'h0, 32'h0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt;
        logic [31:0] alu;
        int          k;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(4, 0) == 0) begin
                wait_req("rand_flush");
                imem_gnt = 1'b1;
                tick();
                imem_gnt = 1'b0;
                k = $urandom_range(3, 0);
                for (int i = 0; i < k; i++) tick();
                do_flush($urandom & 32'hFFFF_FFFC, "rand_flush");
                k = $urandom_range(2, 0);
                for (int i = 0; i < k; i++) begin
                    tests++;
                    if (imem_req !== 1'b0) begin
                        fails++;
                        $display("FAIL rand_drop imem_req=%b required 0", imem_req);
                    end
                    tick();
                end
                imem_rvalid = 1'b1;
                tick();
                imem_rvalid = 1'b0;
            end
            do_fetch(exp_pc, $urandom_range(4, 0), $urandom_range(5, 0), $urandom, "rand");
            tgt = $urandom & 32'hFFFF_FFFC;
            alu = $urandom & 32'hFFFF_FFFD;
            retire(2'($urandom), tgt, alu, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect();
        test_timeout();
        test_flush_wait();
        test_wrap_misalign();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
